// File: rtl/pe_conv_pipe.sv
// Mixed-width conversion PE: join two operand streams, extend, add, narrow (wrap or saturate).
// Optional feature macro: PE_CONV_SAT_EN enables per-token saturation (mode bit1).
module pe_conv_pipe #(
  parameter int unsigned A_W   = 16,
  parameter int unsigned B_W   = 32,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [A_W-1:0]   in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [B_W-1:0]   in1_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [15:0]      tok_count
);

`ifdef PE_CONV_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [ACC_W-1:0] SMAX = ACC_W'({(OUT_W-1){1'b1}});
  localparam logic [ACC_W-1:0] SMIN = ~SMAX;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] en;
  logic             fire;
  logic [A_W-1:0]   a_q;
  logic [B_W-1:0]   b_q;
  logic [1:0]       mode_q;
  logic [ACC_W-1:0] ext_a;
  logic [ACC_W-1:0] ext_b;
  logic [ACC_W-1:0] sum;
  logic [OUT_W-1:0] res_c;

  // Stage k can load when any stage from k onward holds a bubble, or the output drains.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      en[k] = out_ready;
      for (int unsigned j = k; j < DEPTH; j++) begin
        if (!v[j]) en[k] = 1'b1;
      end
    end
  end

  assign fire      = in0_valid && in1_valid && en[0];
  assign in0_ready = in1_valid && en[0] && !rst;
  assign in1_ready = in0_valid && en[0] && !rst;
  assign out_valid = v[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v      <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
    end else begin
      if (en[0]) begin
        v[0] <= fire;
        if (fire) begin
          a_q    <= in0_data;
          b_q    <= in1_data;
          mode_q <= in_mode;
        end
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (en[k]) v[k] <= v[k-1];
      end
    end
  end

  always_comb begin
    if (mode_q[0]) begin
      ext_a = ACC_W'(a_q);
      ext_b = ACC_W'(b_q);
    end else begin
      ext_a = ACC_W'($signed(a_q));
      ext_b = ACC_W'($signed(b_q));
    end
  end

  assign sum = ext_a + ext_b;

  always_comb begin
    res_c = sum[OUT_W-1:0];
    if (SAT_EN && mode_q[1]) begin
      if (mode_q[0]) begin
        if ((sum >> OUT_W) != '0) res_c = '1;
      end else if ($signed(sum) > $signed(SMAX)) begin
        res_c = SMAX[OUT_W-1:0];
      end else if ($signed(sum) < $signed(SMIN)) begin
        res_c = SMIN[OUT_W-1:0];
      end
    end
  end

  // Stage 0 holds raw operands; the narrowed result is registered from stage 1 onward.
  generate
    if (DEPTH == 1) begin : g_d1
      assign out_data = res_c;
    end else begin : g_dn
      logic [OUT_W-1:0] res_q [1:DEPTH-1];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned k = 1; k < DEPTH; k++) res_q[k] <= '0;
        end else begin
          if (en[1]) res_q[1] <= res_c;
          for (int unsigned k = 2; k < DEPTH; k++) begin
            if (en[k]) res_q[k] <= res_q[k-1];
          end
        end
      end
      assign out_data = res_q[DEPTH-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tok_count <= '0;
    else if (out_valid && out_ready) tok_count <= tok_count + 16'd1;
  end

endmodule

// File: tb/tb_pe_conv_pipe.sv
// Scoreboard bench for pe_conv_pipe at default parameters; expectations follow PE_CONV_SAT_EN.
module tb_pe_conv_pipe;

`ifdef PE_CONV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in0_ready;
  logic [15:0] in0_data;
  logic        in1_valid, in1_ready;
  logic [31:0] in1_data;
  logic [1:0]  in_mode;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [15:0] tok_count;

  int errors = 0;
  int checks = 0;
  int fired  = 0;
  logic [15:0] exp_q[$];

  pe_conv_pipe #(.A_W(16), .B_W(32), .ACC_W(32), .OUT_W(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tok_count(tok_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [31:0] b, input logic [1:0] m,
                      input logic [15:0] e);
    bit done = 1'b0;
    in0_data = a; in1_data = b; in_mode = m;
    in0_valid = 1'b1; in1_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in0_ready && in1_ready) begin
        exp_q.push_back(e);
        fired++;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no handshake expected fire for a=%h b=%h", a, b);
    end
  endtask

  // Monitor: pops one expectation for every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got %h expected no token", out_data);
      end else begin
        chk("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    bit saw_valid;
    rst = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = '0; in1_data = '0; in_mode = '0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_tok_count", {16'd0, tok_count}, 32'd0);
    chk("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
    chk("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    // Latency: fired at edge N, visible after edge N+1.
    in0_data = 16'd3; in1_data = 32'd5; in_mode = 2'b00;
    in0_valid = 1'b1; in1_valid = 1'b1;
    @(negedge clk);
    chk("lat_ready", {31'd0, in0_ready}, 32'd1);
    exp_q.push_back(16'd8);
    @(posedge clk); #1;
    in0_valid = 1'b0; in1_valid = 1'b0;
    chk("lat_edge_n", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge_n1", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {16'd0, out_data}, 32'd8);

    send(16'hFFFF, 32'd1,          2'b00, 16'h0000);
    send(16'h7FFF, 32'h0001_0000,  2'b00, 16'h7FFF);
    send(16'd3,    32'd5,          2'b01, 16'd8);
    send(16'hFFFF, 32'd1,          2'b01, 16'h0000);
    send(16'h7FFF, 32'h0001_0000,  2'b01, 16'h7FFF);
    send(16'h7FFF, 32'd1,          2'b10, SAT ? 16'h7FFF : 16'h8000);
    send(16'h7FFF, 32'd1,          2'b00, 16'h8000);
    send(16'h8000, 32'hFFFF_FFFF,  2'b10, SAT ? 16'h8000 : 16'h7FFF);
    send(16'hFFFF, 32'd1,          2'b11, SAT ? 16'hFFFF : 16'h0000);
    send(16'hFFFF, 32'd1,          2'b01, 16'h0000);
    repeat (4) @(posedge clk); #1;

    // Backpressure from a fresh reset so tok_count starts at zero.
    rst = 1'b1; #1; rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0; fired = 0;
    fork
      begin
        send(16'd1, 32'd1, 2'b00, 16'd2);
        send(16'd2, 32'd2, 2'b00, 16'd4);
        send(16'd3, 32'd3, 2'b00, 16'd6);
        send(16'd4, 32'd4, 2'b00, 16'd8);
      end
      begin
        repeat (3) @(posedge clk); #1;
        chk("bp_hold_early", {16'd0, out_data}, 32'd2);
        repeat (2) @(posedge clk); #1;
        chk("bp_fired", fired, 32'd2);
        chk("bp_in0_ready", {31'd0, in0_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_late", {16'd0, out_data}, 32'd2);
        out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("bp_tok_count", {16'd0, tok_count}, 32'd4);
      end
    join

    // Join skew: A waits alone, nothing fires until B arrives.
    in0_data = 16'h0010; in1_data = 32'h20; in_mode = 2'b00;
    in0_valid = 1'b1; in1_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("skew_in0_ready", {31'd0, in0_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("skew_no_out", {31'd0, out_valid}, 32'd0);
    in1_valid = 1'b1;
    @(negedge clk);
    chk("skew_both_ready", {30'd0, in0_ready, in1_ready}, 32'd3);
    exp_q.push_back(16'h0030);
    @(posedge clk); #1;
    in0_valid = 1'b0; in1_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reset with two tokens in flight.
    out_ready = 1'b0;
    send(16'd5, 32'd5, 2'b00, 16'd10);
    send(16'd6, 32'd6, 2'b00, 16'd12);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_tok", {16'd0, tok_count}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("post_rst_stale", {31'd0, saw_valid}, 32'd0);
    chk("post_rst_tok", {16'd0, tok_count}, 32'd0);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
